// File: rtl/buq_pkg.sv
// Shared types for the branch update queue: one queued predictor update
// (branch PC plus resolved direction) and a helper that counts valid
// resolve slots.
package buq_pkg;

  localparam int BUQ_PC_BITS = 32;

  typedef struct packed {
    logic [BUQ_PC_BITS-1:0] pc;
    logic                   taken;
  } upd_entry_t;

  // Number of valid resolve slots presented this cycle (0..2).
  function automatic logic [1:0] n_enq(input logic valid_a, input logic valid_b);
    return {1'b0, valid_a} + {1'b0, valid_b};
  endfunction

endpackage

// File: rtl/branch_update_queue_if.sv
// Resolve-side and predictor-side handshake of the branch update queue.
// The master side is the producer/predictor environment; the slave side is
// the queue itself.
interface branch_update_queue_if #(
  parameter int PC_BITS = 32
);

  logic               enq_valid_a;
  logic [PC_BITS-1:0] enq_pc_a;
  logic               enq_taken_a;
  logic               enq_valid_b;
  logic [PC_BITS-1:0] enq_pc_b;
  logic               enq_taken_b;
  logic               enq_ready;
  logic               upd_hold;
  logic               Wr_En;
  logic [PC_BITS-1:0] Orig_PC;
  logic               is_Taken;

  modport master (
    output enq_valid_a, enq_pc_a, enq_taken_a,
    output enq_valid_b, enq_pc_b, enq_taken_b,
    output upd_hold,
    input  enq_ready, Wr_En, Orig_PC, is_Taken
  );

  modport slave (
    input  enq_valid_a, enq_pc_a, enq_taken_a,
    input  enq_valid_b, enq_pc_b, enq_taken_b,
    input  upd_hold,
    output enq_ready, Wr_En, Orig_PC, is_Taken
  );

endinterface

// File: rtl/buq_fifo_2w1r.sv
// Entry storage for the branch update queue: two write ports landing on
// consecutive entries (wr_ptr, wr_ptr+1) and one asynchronous read port.
// Entries carry no reset; validity is tracked by the controller's count.
module buq_fifo_2w1r
  import buq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     wr_en0,
  input  logic                     wr_en1,
  input  logic [$clog2(DEPTH)-1:0] wr_ptr,
  input  upd_entry_t               wr_data0,
  input  upd_entry_t               wr_data1,
  input  logic [$clog2(DEPTH)-1:0] rd_ptr,
  output upd_entry_t               rd_data
);

  localparam int AW = $clog2(DEPTH);

  upd_entry_t    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr1_s;

  assign wr_ptr1_s = wr_ptr + {{(AW-1){1'b0}}, 1'b1};
  assign rd_data   = mem_r[rd_ptr];

  // Store up to two entries per cycle; port 1 always lands right after port 0.
  always_ff @(posedge clk) begin
    if (wr_en0) begin
      mem_r[wr_ptr] <= wr_data0;
    end
    if (wr_en1) begin
      mem_r[wr_ptr1_s] <= wr_data1;
    end
  end

endmodule

// File: rtl/branch_update_queue.sv
// Branch update queue: accepts up to two resolved branches per cycle and
// drains them in order, one per cycle, onto the predictor update port.
// Optional feature macro: BUQ_BYPASS_EN (empty-queue zero-latency bypass).
module branch_update_queue
  import buq_pkg::*;
#(
  parameter int PC_BITS = BUQ_PC_BITS,
  parameter int DEPTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  branch_update_queue_if.slave   bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] TWO_C   = CW'(2);
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          overflow_r;

  upd_entry_t    slot_a_s;
  upd_entry_t    slot_b_s;
  upd_entry_t    head_s;
  upd_entry_t    wr_data0_s;
  upd_entry_t    wr_data1_s;
  logic          wr_en0_s;
  logic          wr_en1_s;
  logic          enq_ready_s;
  logic          any_valid_s;
  logic          deq_s;
  logic          bypass_s;
  logic [1:0]    n_store_s;
  logic [CW-1:0] count_next_s;

  assign slot_a_s = '{pc: bus.enq_pc_a, taken: bus.enq_taken_a};
  assign slot_b_s = '{pc: bus.enq_pc_b, taken: bus.enq_taken_b};

  // Room for a full dual enqueue, judged on the current count only.
  assign enq_ready_s = (DEPTH_C - count_r) >= TWO_C;
  assign any_valid_s = bus.enq_valid_a | bus.enq_valid_b;
  assign deq_s       = (count_r != ZERO_C) & ~bus.upd_hold;

`ifdef BUQ_BYPASS_EN
  // Empty queue and drain allowed: the oldest valid slot goes straight out.
  assign bypass_s = (count_r == ZERO_C) & ~bus.upd_hold & any_valid_s & enq_ready_s;
`else
  assign bypass_s = 1'b0;
`endif

  buq_fifo_2w1r #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .wr_en0   (wr_en0_s),
    .wr_en1   (wr_en1_s),
    .wr_ptr   (wr_ptr_r),
    .wr_data0 (wr_data0_s),
    .wr_data1 (wr_data1_s),
    .rd_ptr   (rd_ptr_r),
    .rd_data  (head_s)
  );

  // Compact accepted slots into consecutive entries, oldest (a) first.
  always_comb begin
    wr_en0_s   = 1'b0;
    wr_en1_s   = 1'b0;
    wr_data0_s = slot_a_s;
    wr_data1_s = slot_b_s;
    n_store_s  = 2'd0;
    if (enq_ready_s & ~bypass_s) begin
      n_store_s = n_enq(bus.enq_valid_a, bus.enq_valid_b);
      case ({bus.enq_valid_a, bus.enq_valid_b})
        2'b11: begin
          wr_en0_s = 1'b1;
          wr_en1_s = 1'b1;
        end
        2'b10: begin
          wr_en0_s = 1'b1;
        end
        2'b01: begin
          wr_en0_s   = 1'b1;
          wr_data0_s = slot_b_s;
        end
        default: begin
          wr_en0_s = 1'b0;
        end
      endcase
    end else if (bypass_s) begin
      // The oldest slot is consumed by the bypass; only a younger b is kept.
      n_store_s  = n_enq(bus.enq_valid_a, bus.enq_valid_b) - 2'd1;
      wr_en0_s   = bus.enq_valid_a & bus.enq_valid_b;
      wr_data0_s = slot_b_s;
    end else begin
      n_store_s = 2'd0;
    end
  end

  assign count_next_s = count_r + {{(CW-2){1'b0}}, n_store_s} - {{(CW-1){1'b0}}, deq_s};

  // Predictor update port: bypassed slot, else queue head, else quiet zeros.
  always_comb begin
    bus.Wr_En    = 1'b0;
    bus.Orig_PC  = {PC_BITS{1'b0}};
    bus.is_Taken = 1'b0;
    if (rst) begin
      bus.Wr_En = 1'b0;
    end else if (bypass_s) begin
      bus.Wr_En    = 1'b1;
      bus.Orig_PC  = bus.enq_valid_a ? bus.enq_pc_a : bus.enq_pc_b;
      bus.is_Taken = bus.enq_valid_a ? bus.enq_taken_a : bus.enq_taken_b;
    end else if (deq_s) begin
      bus.Wr_En    = 1'b1;
      bus.Orig_PC  = head_s.pc;
      bus.is_Taken = head_s.taken;
    end else begin
      bus.Wr_En = 1'b0;
    end
  end

  // Status outputs read as post-reset values throughout the reset cycle.
  assign bus.enq_ready = rst | enq_ready_s;
  assign count         = rst ? ZERO_C : count_r;
  assign overflow_err  = ~rst & overflow_r;

  // Pointer, occupancy and sticky overflow state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r   <= {AW{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      count_r    <= ZERO_C;
      overflow_r <= 1'b0;
    end else begin
      rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, deq_s};
      wr_ptr_r <= wr_ptr_r + {{(AW-2){1'b0}}, n_store_s};
      count_r  <= count_next_s;
      if (any_valid_s & ~enq_ready_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_update_queue.sv
// Self-checking bench for branch_update_queue. A queue-based reference model
// predicts every cycle's update port, count, enq_ready and overflow_err.
module tb_branch_update_queue;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  count;
  logic        overflow_err;
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;

  branch_update_queue_if #(.PC_BITS(32)) bus ();

  branch_update_queue #(.PC_BITS(32), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .count        (count),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  // Reference model state and per-cycle expectation.
  ent_t        mq[$];
  bit          m_ovf;
  logic        exp_wr, exp_tk, exp_rdy, exp_ovf, exp_byp;
  logic [31:0] exp_pc;
  logic [3:0]  exp_cnt;
  logic [39:0] exp_vec;
  wire  [39:0] obs = {bus.Wr_En, bus.Orig_PC, bus.is_Taken, count, bus.enq_ready, overflow_err};

  task automatic drive(input logic va, input logic [31:0] pa, input logic ta,
                       input logic vb, input logic [31:0] pb, input logic tb_,
                       input logic hold, input logic r);
    bus.enq_valid_a = va;  bus.enq_pc_a = pa;  bus.enq_taken_a = ta;
    bus.enq_valid_b = vb;  bus.enq_pc_b = pb;  bus.enq_taken_b = tb_;
    bus.upd_hold    = hold;
    rst             = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Expected outputs for the current inputs and model contents.
  task automatic model_eval();
    exp_wr = 1'b0; exp_pc = 32'h0; exp_tk = 1'b0; exp_byp = 1'b0;
    if (rst) begin
      exp_cnt = 4'd0; exp_rdy = 1'b1; exp_ovf = 1'b0;
    end else begin
      exp_cnt = 4'(mq.size());
      exp_rdy = (DEPTH - mq.size()) >= 2;
      exp_ovf = m_ovf;
`ifdef BUQ_BYPASS_EN
      if (mq.size() == 0 && !bus.upd_hold && (bus.enq_valid_a || bus.enq_valid_b)) begin
        exp_byp = 1'b1;
        exp_wr  = 1'b1;
        exp_pc  = bus.enq_valid_a ? bus.enq_pc_a : bus.enq_pc_b;
        exp_tk  = bus.enq_valid_a ? bus.enq_taken_a : bus.enq_taken_b;
      end else
`endif
      if (mq.size() > 0 && !bus.upd_hold) begin
        exp_wr = 1'b1;
        exp_pc = mq[0].pc;
        exp_tk = mq[0].taken;
      end
    end
    exp_vec = {exp_wr, exp_pc, exp_tk, exp_cnt, exp_rdy, exp_ovf};
  endtask

  // Advance the model by the clock edge that follows model_eval.
  task automatic model_commit();
    ent_t arr[$];
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      if (exp_wr && !exp_byp) void'(mq.pop_front());
      if (bus.enq_valid_a) arr.push_back('{pc: bus.enq_pc_a, taken: bus.enq_taken_a});
      if (bus.enq_valid_b) arr.push_back('{pc: bus.enq_pc_b, taken: bus.enq_taken_b});
      if (exp_rdy) begin
        if (exp_byp) void'(arr.pop_front());
        foreach (arr[i]) mq.push_back(arr[i]);
      end else if (arr.size() > 0) begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive($urandom_range(0, 1), $urandom, 1'b1, $urandom_range(0, 1), $urandom, 1'b0, 1'b0, 1'b1);
      #3; model_eval(); checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
      model_commit(); tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #3; checks++;
    if ({bus.Wr_En, count, bus.enq_ready, overflow_err} !== {1'b0, 4'd0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL reset_after got=%b/%0d/%b/%b", bus.Wr_En, count, bus.enq_ready, overflow_err);
    end
    model_eval(); model_commit(); tick();
  endtask

  task automatic test_single();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(1, 32'h100, 1, 0, 0, 0, 0, 0);
      else        drive(0, 0, 0, 0, 0, 0, 0, 0);
      #3; model_eval(); checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL single cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
`ifdef BUQ_BYPASS_EN
      if (i == 0) begin
`else
      if (i == 1) begin
`endif
        checks++;
        if ({bus.Wr_En, bus.Orig_PC, bus.is_Taken} !== {1'b1, 32'h100, 1'b1}) begin
          failures++; $display("FAIL single_out got=%b/%h/%b exp=1/00000100/1", bus.Wr_En, bus.Orig_PC, bus.is_Taken);
        end
      end
      model_commit(); tick();
    end
  endtask

  task automatic test_dual();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive(1, 32'h200, 0, 1, 32'h204, 1, 0, 0);
      else        drive(0, 0, 0, 0, 0, 0, 0, 0);
      #3; model_eval(); checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL dual cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
      model_commit(); tick();
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) begin
      drive(1, $urandom, $urandom_range(0, 1), 1, $urandom, $urandom_range(0, 1), 1, 0);
      #3; model_eval(); checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL full_fill cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
      if (i == 4) begin
        checks++;
        if ({count, bus.enq_ready} !== {4'd8, 1'b0}) begin
          failures++; $display("FAIL full_level got=%0d/%b exp=8/0", count, bus.enq_ready);
        end
      end
      model_commit(); tick();
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    #3; checks++;
    if ({overflow_err, count} !== {1'b1, 4'd8}) begin
      failures++; $display("FAIL full_drop got=%b/%0d exp=1/8", overflow_err, count);
    end
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #3; model_eval(); checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL full_drain cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
      model_commit(); tick();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] sent[$];
    logic [31:0] seen[$];
    int          n_dual = 0;
    int          budget = 0;
    while ((n_dual < 24 || mq.size() > 0) && budget < 300) begin
      if (n_dual < 24 && bus.enq_ready) begin
        logic [31:0] pa, pb;
        pa = $urandom; pb = $urandom;
        sent.push_back(pa); sent.push_back(pb);
        drive(1, pa, pa[0], 1, pb, pb[0], 0, 0);
        n_dual++;
      end else begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
      end
      #3; model_eval(); checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
      if (bus.Wr_En) seen.push_back(bus.Orig_PC);
      model_commit(); tick();
      budget++;
    end
    checks++;
    if (seen.size() != 48 || budget >= 300) begin
      failures++; $display("FAIL wrap_total got=%0d exp=48 cycles=%0d", seen.size(), budget);
    end
    for (int i = 0; i < 48 && i < seen.size(); i++) begin
      checks++;
      if (seen[i] !== sent[i]) begin failures++; $display("FAIL wrap_order idx=%0d got=%h exp=%h", i, seen[i], sent[i]); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1, $urandom, 1, (i < 2), $urandom, 0, 1, 0);
      #3; model_eval(); model_commit(); tick();
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    #3; checks++;
    if (count !== 4'd5) begin failures++; $display("FAIL midrst_level got=%0d exp=5", count); end
    drive(1, 32'h55, 1, 0, 0, 0, 0, 1);
    #3; model_eval(); checks++;
    if (obs !== exp_vec) begin failures++; $display("FAIL midrst_rst cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
    model_commit(); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #3; checks++;
    if ({count, bus.Wr_En, overflow_err} !== {4'd0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL midrst_after got=%0d/%b/%b exp=0/0/0", count, bus.Wr_En, overflow_err);
    end
    model_eval(); model_commit(); tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(1, 32'h300, 0, 0, 0, 0, 0, 0);
      else        drive(0, 0, 0, 0, 0, 0, 0, 0);
      #3; model_eval(); checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL midrst_enq cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
      model_commit(); tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1), $urandom, $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom, $urandom_range(0, 1),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 59) == 0));
      #3; model_eval(); checks++;
      if (obs !== exp_vec) begin failures++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_vec); end
      model_commit(); tick();
    end
  endtask

  initial begin
    m_ovf = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_dual();
    test_full();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
